// File: rtl/systolic_psum_accumulator_if.sv
// -----------------------------------------------------------------------------
// systolic_psum_accumulator_if
// Handshake bundle between a systolic array, the psum accumulator and the
// consumer of finished rows.
//   psum_valid / psum_in        : psum row from the array (one row per valid)
//   tile_first / tile_last      : tile qualifiers, meaningful with row 0
//   in_ready                    : accumulator accepts rows
//   acc_out / out_valid         : drained row towards the consumer
//   out_ready                   : consumer accepts acc_out
//   overflow_err                : sticky "row arrived while not ready"
// master = producer/consumer side (testbench), slave = accumulator.
// -----------------------------------------------------------------------------
interface systolic_psum_accumulator_if #(
   parameter int unsigned PSUM_WIDTH  = 32,
   parameter int unsigned ACC_WIDTH   = 40,
   parameter int unsigned ARRAY_WIDTH = 4
);
   logic                                   psum_valid;
   logic [ARRAY_WIDTH-1:0][PSUM_WIDTH-1:0] psum_in;
   logic                                   tile_first;
   logic                                   tile_last;
   logic                                   in_ready;
   logic [ARRAY_WIDTH-1:0][ACC_WIDTH-1:0]  acc_out;
   logic                                   out_valid;
   logic                                   out_ready;
   logic                                   overflow_err;

   modport master (
      output psum_valid, psum_in, tile_first, tile_last, out_ready,
      input  in_ready, acc_out, out_valid, overflow_err
   );

   modport slave (
      input  psum_valid, psum_in, tile_first, tile_last, out_ready,
      output in_ready, acc_out, out_valid, overflow_err
   );
endinterface

// File: rtl/systolic_psum_accumulator.sv
// -----------------------------------------------------------------------------
// systolic_psum_accumulator
// Captures psum rows from a systolic array into a ROWS-deep buffer, either
// overwriting (first tile) or accumulating (later tiles) per lane, and drains
// the finished rows over a valid/ready handshake after the last tile.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : systolic_psum_accumulator_if.slave (row input, drain output, error)
// Lanes are signed two's complement; accumulation wraps at ACC_WIDTH.
// -----------------------------------------------------------------------------
module systolic_psum_accumulator #(
   parameter int unsigned PSUM_WIDTH  = 32,
   parameter int unsigned ACC_WIDTH   = 40,
   parameter int unsigned ARRAY_WIDTH = 4,
   parameter int unsigned ROWS        = 4
) (
   input logic                          clk,
   input logic                          rst_n,
   systolic_psum_accumulator_if.slave   bus
);

   localparam int unsigned PtrW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [PtrW-1:0] LastRow = PtrW'(ROWS - 1);

   typedef logic [ARRAY_WIDTH-1:0][ACC_WIDTH-1:0] row_t;
   typedef enum logic {StAccum, StDrain} state_e;

   state_e            r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_overflow_err;
   logic [PtrW-1:0]   r_wr_ptr;
   logic [PtrW-1:0]   r_rd_ptr;
   logic              r_cur_first;
   logic              r_cur_last;
   row_t              r_buf [ROWS];

   logic              w_first;
   logic              w_last;
   row_t              w_wr_row;
   logic [ACC_WIDTH-1:0] w_ext;

   // Row 0 must use the flags presented with it, not the previous tile's copy.
   always_comb begin
      w_first  = (r_wr_ptr == '0) ? bus.tile_first : r_cur_first;
      w_last   = (r_wr_ptr == '0) ? bus.tile_last  : r_cur_last;
      w_ext    = '0;
      w_wr_row = '0;
      for (int i = 0; i < int'(ARRAY_WIDTH); i++) begin
         // Size cast of a signed operand sign-extends (also valid when widths match).
         w_ext       = ACC_WIDTH'($signed(bus.psum_in[i]));
         w_wr_row[i] = w_first ? w_ext : (r_buf[r_wr_ptr][i] + w_ext);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= StAccum;
         r_in_ready     <= 1'b1;
         r_out_valid    <= 1'b0;
         r_overflow_err <= 1'b0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_cur_first    <= 1'b0;
         r_cur_last     <= 1'b0;
         for (int r = 0; r < int'(ROWS); r++) begin
            r_buf[r] <= '0;
         end
      end else begin
         unique case (r_state)
            StAccum: begin
               if (bus.psum_valid) begin
                  r_buf[r_wr_ptr] <= w_wr_row;
                  if (r_wr_ptr == '0) begin
                     r_cur_first <= bus.tile_first;
                     r_cur_last  <= bus.tile_last;
                  end
                  if (r_wr_ptr == LastRow) begin
                     r_wr_ptr <= '0;
                     if (w_last) begin
                        r_state     <= StDrain;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                     end
                  end else begin
                     r_wr_ptr <= r_wr_ptr + PtrW'(1);
                  end
               end
            end
            StDrain: begin
               // Rows offered while draining are dropped; only the flag records them.
               if (bus.psum_valid) begin
                  r_overflow_err <= 1'b1;
               end
               if (bus.out_ready) begin
                  if (r_rd_ptr == LastRow) begin
                     r_rd_ptr    <= '0;
                     r_state     <= StAccum;
                     r_in_ready  <= 1'b1;
                     r_out_valid <= 1'b0;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + PtrW'(1);
                  end
               end
            end
            default: begin
               r_state     <= StAccum;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = r_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.overflow_err = r_overflow_err;
   assign bus.acc_out      = r_buf[r_rd_ptr];

endmodule

// File: tb/tb_systolic_psum_accumulator.sv
module tb_systolic_psum_accumulator;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   systolic_psum_accumulator_if #(.PSUM_WIDTH(32), .ACC_WIDTH(40), .ARRAY_WIDTH(4)) bus ();
   systolic_psum_accumulator_if #(.PSUM_WIDTH(32), .ACC_WIDTH(32), .ARRAY_WIDTH(1)) wbus ();

   systolic_psum_accumulator #(
      .PSUM_WIDTH(32), .ACC_WIDTH(40), .ARRAY_WIDTH(4), .ROWS(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Narrow instance: accumulator as wide as the psum, to exercise wrap-around.
   systolic_psum_accumulator #(
      .PSUM_WIDTH(32), .ACC_WIDTH(32), .ARRAY_WIDTH(1), .ROWS(2)
   ) dut_w (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (wbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int base [4][4] = '{
      '{90, 100, 110, 120},
      '{218, 244, 270, 296},
      '{346, 388, 430, 472},
      '{474, 532, 590, 648}
   };

   typedef struct {
      logic first;
      logic last;
      int   scale;
      int   gap;
      int   exp_scale;
   } vec_t;

   vec_t tbl [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Rows 1..3 carry inverted flags, which the block must ignore.
   task automatic send_tile(input logic first, input logic last, input int scale,
                            input int gap);
      for (int r = 0; r < 4; r++) begin
         bus.psum_valid = 1'b1;
         bus.tile_first = (r == 0) ? first : ~first;
         bus.tile_last  = (r == 0) ? last : ~last;
         for (int l = 0; l < 4; l++) bus.psum_in[l] = 32'(scale * base[r][l]);
         step();
         bus.psum_valid = 1'b0;
         bus.tile_first = 1'b0;
         bus.tile_last  = 1'b0;
         if (r < 3) repeat (gap) step();
      end
   endtask

   task automatic drain_check(input int scale, input string tag);
      check({tag, " out_valid rise"}, 64'(bus.out_valid), 64'd1);
      check({tag, " in_ready low"}, 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         check($sformatf("%s drain valid r%0d", tag, r), 64'(bus.out_valid), 64'd1);
         for (int l = 0; l < 4; l++)
            check($sformatf("%s r%0d l%0d", tag, r, l), $signed(bus.acc_out[l]),
                  64'(longint'(scale) * base[r][l]));
         step();
      end
      bus.out_ready = 1'b0;
      check({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
      check({tag, " out_valid fall"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pat [10] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
      int idx;
      n_checks = 0;
      n_errors = 0;

      tbl[0] = '{first: 1'b1, last: 1'b1, scale: 1,  gap: 0, exp_scale: 1};
      tbl[1] = '{first: 1'b1, last: 1'b0, scale: 1,  gap: 0, exp_scale: 0};
      tbl[2] = '{first: 1'b0, last: 1'b1, scale: 1,  gap: 2, exp_scale: 2};
      tbl[3] = '{first: 1'b1, last: 1'b0, scale: -1, gap: 1, exp_scale: 0};
      tbl[4] = '{first: 1'b0, last: 1'b0, scale: 3,  gap: 0, exp_scale: 0};
      tbl[5] = '{first: 1'b0, last: 1'b1, scale: -5, gap: 0, exp_scale: -3};

      rst_n           = 1'b0;
      bus.psum_valid  = 1'b0;
      bus.psum_in     = '0;
      bus.tile_first  = 1'b0;
      bus.tile_last   = 1'b0;
      bus.out_ready   = 1'b0;
      wbus.psum_valid = 1'b0;
      wbus.psum_in    = '0;
      wbus.tile_first = 1'b0;
      wbus.tile_last  = 1'b0;
      wbus.out_ready  = 1'b0;
      #12;
      check("reset in_ready", 64'(bus.in_ready), 64'd1);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset overflow", 64'(bus.overflow_err), 64'd0);
      for (int l = 0; l < 4; l++)
         check($sformatf("reset acc l%0d", l), $signed(bus.acc_out[l]), 64'sd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Table: single tile, two-tile accumulate with gaps, three-tile negative.
      for (int t = 0; t < 6; t++) begin
         send_tile(tbl[t].first, tbl[t].last, tbl[t].scale, tbl[t].gap);
         if (tbl[t].last) drain_check(tbl[t].exp_scale, $sformatf("vec%0d", t));
         else check($sformatf("vec%0d stay accum", t), 64'(bus.in_ready), 64'd1);
      end

      // Backpressure: acc_out must hold while out_ready is low.
      send_tile(1'b1, 1'b1, 2, 0);
      idx = 0;
      for (int c = 0; c < 10 && idx < 4; c++) begin
         bus.out_ready = pat[c][0];
         check($sformatf("bp valid c%0d", c), 64'(bus.out_valid), 64'd1);
         for (int l = 0; l < 4; l++)
            check($sformatf("bp c%0d l%0d", c, l), $signed(bus.acc_out[l]),
                  64'(2 * base[idx][l]));
         if (pat[c] != 0) idx++;
         step();
      end
      bus.out_ready = 1'b0;
      check("bp transfers", 64'(idx), 64'd4);
      check("bp in_ready", 64'(bus.in_ready), 64'd1);

      // Overflow: row offered during drain is dropped, flag sticks.
      send_tile(1'b1, 1'b1, 1, 0);
      check("ovf before", 64'(bus.overflow_err), 64'd0);
      bus.psum_valid = 1'b1;
      for (int l = 0; l < 4; l++) bus.psum_in[l] = 32'd999;
      step();
      bus.psum_valid = 1'b0;
      check("ovf set", 64'(bus.overflow_err), 64'd1);
      drain_check(1, "ovf");
      check("ovf sticky", 64'(bus.overflow_err), 64'd1);
      // Buffer and wr_ptr untouched by the dropped row: next tile adds on top.
      send_tile(1'b0, 1'b1, 1, 0);
      drain_check(2, "ovf acc");

      // Reset mid-drain.
      send_tile(1'b1, 1'b1, 3, 0);
      bus.out_ready = 1'b1;
      step();
      step();
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      #2;
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst in_ready", 64'(bus.in_ready), 64'd1);
      check("rst overflow", 64'(bus.overflow_err), 64'd0);
      for (int l = 0; l < 4; l++)
         check($sformatf("rst acc l%0d", l), $signed(bus.acc_out[l]), 64'sd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      // No tile_first: adds onto the cleared buffer, so only new data appears.
      send_tile(1'b0, 1'b1, 1, 0);
      drain_check(1, "post rst");

      // Wrap at ACC_WIDTH = PSUM_WIDTH = 32, and -5 + 3.
      wbus.psum_valid = 1'b1;
      wbus.tile_first = 1'b1;
      wbus.tile_last  = 1'b0;
      wbus.psum_in[0] = 32'h7FFF_FFFF;
      step();
      wbus.tile_first = 1'b0;
      wbus.psum_in[0] = 32'hFFFF_FFFB;
      step();
      wbus.tile_last  = 1'b1;
      wbus.psum_in[0] = 32'd1;
      step();
      wbus.tile_last  = 1'b0;
      wbus.psum_in[0] = 32'd3;
      step();
      wbus.psum_valid = 1'b0;
      check("wrap out_valid", 64'(wbus.out_valid), 64'd1);
      check("wrap lane0", $signed(wbus.acc_out[0]), -64'sd2147483648);
      wbus.out_ready = 1'b1;
      step();
      check("neg lane0", $signed(wbus.acc_out[0]), -64'sd2);
      step();
      wbus.out_ready = 1'b0;
      check("wrap in_ready", 64'(wbus.in_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
